// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared fetch state, PC step, reset PC and FIFO entry type
package cpu_fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_e;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch FIFO of {pc, instr} entries with flush taking priority
module fetch_fifo
  import cpu_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  fetch_entry_t             entry_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  // next storage, pointers and occupancy; a flush wipes pointers and count
  always_comb begin
    do_pop = pop_i && cnt_q != '0;
    do_push = push_i && (cnt_q != (AW+1)'(DEPTH) || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = entry_i;
    rd_d = flush_i ? '0 : rd_q + AW'(do_pop);
    wr_d = flush_i ? '0 : wr_q + AW'(do_push);
    cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // storage is cleared on reset so the head reads zero afterwards
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  assign head_o = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch PC owner, imem req/gnt/rvalid master and prefetch queue to decode
module instr_fetch_queue
  import cpu_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  output logic                   imem_req_o,
  output logic [31:0]            imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [31:0]            imem_rdata_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  output logic                   instr_valid_o,
  output logic [31:0]            instr_o,
  output logic [31:0]            pc_o,
  input  logic                   instr_ready_i,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] FULL = (AW+2)'(DEPTH);
  fetch_state_e state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic drop_q, drop_d, push, pop;
  logic [AW+1:0] after;
  fetch_entry_t head;
  assign pop = instr_valid_o && instr_ready_i;
  // fetch FSM: redirect first, then request/grant/response sequencing with space reserved at grant
  always_comb begin
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d = req_pc_q;
    drop_d = drop_q;
    push = 1'b0;
    after = {1'b0, count_o} + (AW+2)'(!drop_q) - (AW+2)'(pop);
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ~32'h3;
      drop_d = (state_q == WAIT && !imem_rvalid_i) || (state_q == REQ && imem_gnt_i);
      state_d = drop_d ? WAIT : IDLE;
    end else if (state_q == IDLE) begin
      state_d = {1'b0, count_o} < FULL ? REQ : IDLE;
    end else if (state_q == REQ) begin
      if (imem_gnt_i) begin
        req_pc_d = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + PC_STEP;
        state_d = WAIT;
      end
    end else if (imem_rvalid_i) begin
      push = !drop_q;
      drop_d = 1'b0;
      state_d = after < FULL ? REQ : IDLE;
    end
  end
  // fetch state registers
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q <= req_pc_d;
      drop_q <= drop_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .flush_i (redirect_i),
    .push_i  (push),
    .pop_i   (pop),
    .entry_i ('{pc: req_pc_q, instr: imem_rdata_i}),
    .head_o  (head),
    .count_o (count_o)
  );
  assign imem_req_o = state_q == REQ;
  assign imem_addr_o = fetch_pc_q;
  assign instr_valid_o = count_o != '0;
  assign instr_o = head.instr;
  assign pc_o = head.pc;
endmodule
